// File: rtl/mem_pkg.sv
// Shared definitions for the DRAM write path: burst geometry, the address
// width and the burst-writer FSM state encoding. The arbiter imports this too.
package mem_pkg;

    localparam int ADDR_W      = 29;
    localparam int BEAT_W      = 128;
    localparam int BURST_BEATS = 4;
    localparam int ADDR_STEP   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2
    } wr_state_e;

    // Counter increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/la_beat_fifo.sv
// Single-clock first-word-fall-through beat buffer. The head entry is always
// presented on head_o, so a consumer can use it in the same cycle it pops.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module la_beat_fifo #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Beat storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/la_burst_writer.sv
// Logic-analyser capture writer: buffers 128-bit capture beats and drains
// them to DRAM as fixed 4-beat bursts over a request/ack handshake, stepping
// through a circular address window [base_addr, end_addr].
module la_burst_writer
    import mem_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int BURST_BEATS = mem_pkg::BURST_BEATS,
    parameter int ADDR_STEP   = mem_pkg::ADDR_STEP
) (
    input  logic              clk_ram_2x,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              in_valid,
    input  logic [BEAT_W-1:0] in_data,
    output logic              wr_en,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BEAT_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              capturing,
    output logic              overflow,
    output logic              wrapped,
    output logic [31:0]       burst_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int BCW   = $clog2(BURST_BEATS) + 1;

    wr_state_e         state_q;
    logic              wr_en_q;
    logic              wr_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] end_q;
    logic              reload_q;
    logic              wrapped_q;
    logic [31:0]       burst_cnt_q;
    logic [BCW-1:0]    beat_q;
    logic [1:0]        rst_sync_q;
    logic              capturing_q;
    logic              capturing_d;
    logic              overflow_q;
    logic              overflow_d;

    logic              run;
    logic              push;
    logic              pop;
    logic              flush;
    logic [BEAT_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;

    assign run   = rst_sync_q[1];
    assign pop   = ((state_q == REQ) && wr_ack) || (state_q == BURST);
    assign flush = arm && (state_q == IDLE);
    assign push  = capturing_q && in_valid && (!fifo_full || pop);

    la_beat_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (BEAT_W)
    ) u_fifo (
        .clk_i   (clk_ram_2x),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (in_data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full)
    );

    // Reset release is retimed through two flops before the FSM may start a burst.
    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // Capture enable and sticky overflow; stop takes priority over arm.
    always_comb begin
        capturing_d = capturing_q;
        overflow_d  = overflow_q;
        if (capturing_q && in_valid && !push) begin
            overflow_d = 1'b1;
        end
        if (arm) begin
            capturing_d = 1'b1;
            overflow_d  = 1'b0;
        end
        if (stop) begin
            capturing_d = 1'b0;
        end
    end

    // Registers for the capture state computed above.
    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) begin
            capturing_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            capturing_q <= capturing_d;
            overflow_q  <= overflow_d;
        end
    end

    // Burst FSM with registered handshake outputs, address walk and burst status.
    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            base_q      <= '0;
            end_q       <= '0;
            reload_q    <= 1'b0;
            wrapped_q   <= 1'b0;
            burst_cnt_q <= '0;
            beat_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_valid_q <= 1'b0;
                    // A re-arm seen during a burst applies its base here.
                    if (reload_q) begin
                        wr_addr_q <= base_q;
                        reload_q  <= 1'b0;
                    end
                    // Arm in IDLE flushes the buffer, so never start on that cycle.
                    if (run && !arm && (fifo_count >= CNT_W'(BURST_BEATS))) begin
                        state_q <= REQ;
                        wr_en_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (wr_ack) begin
                        state_q    <= BURST;
                        wr_en_q    <= 1'b0;
                        wr_valid_q <= 1'b1;
                        beat_q     <= BCW'(1);
                    end
                end
                BURST: begin
                    if (beat_q == BCW'(BURST_BEATS - 1)) begin
                        state_q     <= IDLE;
                        wr_valid_q  <= 1'b0;
                        burst_cnt_q <= sat_inc32(burst_cnt_q);
                        if (wr_addr_q == end_q) begin
                            wr_addr_q <= base_q;
                            wrapped_q <= 1'b1;
                        end else begin
                            wr_addr_q <= wr_addr_q + ADDR_W'(ADDR_STEP);
                        end
                    end else begin
                        beat_q <= beat_q + BCW'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    wr_en_q    <= 1'b0;
                    wr_valid_q <= 1'b0;
                end
            endcase

            if (arm) begin
                base_q      <= base_addr;
                end_q       <= end_addr;
                wrapped_q   <= 1'b0;
                burst_cnt_q <= '0;
                if (state_q == IDLE) begin
                    wr_addr_q <= base_addr;
                    reload_q  <= 1'b0;
                end else begin
                    reload_q  <= 1'b1;
                end
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = ((state_q == REQ) || (state_q == BURST)) ? fifo_head : '0;
    assign capturing   = capturing_q;
    assign overflow    = overflow_q;
    assign wrapped     = wrapped_q;
    assign burst_count = burst_cnt_q;

endmodule

// File: tb/tb_la_burst_writer.sv
// Directed bench for la_burst_writer: single burst, address wrap, overflow,
// stray ack, stop with residue, arm+stop, and reset mid-burst.
module tb_la_burst_writer;

    logic         clk_ram_2x = 1'b0;
    logic         rst_n;
    logic         arm;
    logic         stop;
    logic [28:0]  base_addr;
    logic [28:0]  end_addr;
    logic         in_valid;
    logic [127:0] in_data;
    logic         wr_en;
    logic         wr_valid;
    logic [28:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_ack;
    logic         capturing;
    logic         overflow;
    logic         wrapped;
    logic [31:0]  burst_count;

    int checks = 0;
    int errors = 0;

    logic [28:0]  baddr [16];
    logic         bwrap [16];
    logic [127:0] got   [64];
    int           nb;
    int           ng;

    always #5 clk_ram_2x = ~clk_ram_2x;

    la_burst_writer #(.DEPTH(32)) dut (
        .clk_ram_2x  (clk_ram_2x),
        .rst_n       (rst_n),
        .arm         (arm),
        .stop        (stop),
        .base_addr   (base_addr),
        .end_addr    (end_addr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .wr_en       (wr_en),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .capturing   (capturing),
        .overflow    (overflow),
        .wrapped     (wrapped),
        .burst_count (burst_count)
    );

    function automatic logic [127:0] beat(input logic [7:0] tag, input int i);
        return {4{tag, 24'(i)}};
    endfunction

    task automatic step();
        @(posedge clk_ram_2x);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic [28:0] b, input logic [28:0] e, input logic s);
        base_addr = b;
        end_addr  = e;
        arm       = 1'b1;
        stop      = s;
        step();
        arm  = 1'b0;
        stop = 1'b0;
    endtask

    // Acks every request immediately, records burst addresses and drained beats.
    task automatic run_cycles(input int ncyc, input int npush, input logic [7:0] tag, input bit extra);
        bit extra_done;
        extra_done = 1'b0;
        nb = 0;
        ng = 0;
        for (int i = 0; i < ncyc; i++) begin
            in_valid = 1'b0;
            if (wr_en) begin
                if (nb < 16) begin
                    baddr[nb] = wr_addr;
                    bwrap[nb] = wrapped;
                end
                nb++;
                if (ng < 64) got[ng] = wr_data;
                ng++;
                wr_ack = 1'b1;
                if (extra && !extra_done) begin
                    in_valid   = 1'b1;
                    in_data    = beat(8'hEE, 0);
                    extra_done = 1'b1;
                end
            end else begin
                wr_ack = 1'b0;
            end
            if (wr_valid) begin
                if (ng < 64) got[ng] = wr_data;
                ng++;
            end
            if (i < npush) begin
                in_valid = 1'b1;
                in_data  = beat(tag, i);
            end
            step();
        end
        wr_ack   = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        bit got_en;
        bit seen;

        rst_n     = 1'b0;
        arm       = 1'b0;
        stop      = 1'b0;
        base_addr = '0;
        end_addr  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        wr_ack    = 1'b0;
        repeat (3) step();

        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_capturing", capturing, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_burst_count", burst_count, 0);

        rst_n = 1'b1;
        repeat (3) step();

        // Single burst, ack three cycles after the request.
        do_arm(29'h100, 29'h118, 1'b0);
        chk("s1_capturing", capturing, 1);
        chk("s1_addr_loaded", wr_addr, 29'h100);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = beat(8'hA0, k);
            step();
        end
        in_valid = 1'b0;
        chk("s1_wr_en_not_yet", wr_en, 0);
        step();
        chk("s1_wr_en_rise", wr_en, 1);
        chk("s1_req_wr_valid", wr_valid, 0);
        chk("s1_req_addr", wr_addr, 29'h100);
        chk("s1_req_head", wr_data, beat(8'hA0, 0));
        step();
        step();
        wr_ack = 1'b1;
        chk("s1_ack_wr_en", wr_en, 1);
        chk("s1_ack_data_a0", wr_data, beat(8'hA0, 0));
        step();
        wr_ack = 1'b0;
        chk("s1_b1_valid", wr_valid, 1);
        chk("s1_b1_wr_en", wr_en, 0);
        chk("s1_b1_data", wr_data, beat(8'hA0, 1));
        step();
        chk("s1_b2_valid", wr_valid, 1);
        chk("s1_b2_data", wr_data, beat(8'hA0, 2));
        step();
        chk("s1_b3_valid", wr_valid, 1);
        chk("s1_b3_data", wr_data, beat(8'hA0, 3));
        step();
        chk("s1_end_valid", wr_valid, 0);
        chk("s1_burst_count", burst_count, 1);
        chk("s1_next_addr", wr_addr, 29'h108);

        // 20 beats with immediate acks walk the window and wrap once.
        do_arm(29'h100, 29'h118, 1'b0);
        chk("s2_burst_count_cleared", burst_count, 0);
        run_cycles(40, 20, 8'hB0, 1'b0);
        chk("s2_num_bursts", nb, 5);
        chk("s2_addr0", baddr[0], 29'h100);
        chk("s2_addr1", baddr[1], 29'h108);
        chk("s2_addr2", baddr[2], 29'h110);
        chk("s2_addr3", baddr[3], 29'h118);
        chk("s2_addr4", baddr[4], 29'h100);
        chk("s2_wrap_before", bwrap[3], 0);
        chk("s2_wrap_after", bwrap[4], 1);
        chk("s2_num_beats", ng, 20);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("s2_beat%0d", i), got[i], beat(8'hB0, i));
        end
        chk("s2_burst_count", burst_count, 5);
        chk("s2_wrapped", wrapped, 1);

        // Ack withheld while 40 beats stream into a 32-deep buffer.
        do_arm(29'h100, 29'h118, 1'b0);
        chk("s3_wrapped_cleared", wrapped, 0);
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = beat(8'hC0, i);
            step();
            if (i == 31) begin
                chk("s3_overflow_at_full", overflow, 0);
                chk("s3_count_full", dut.u_fifo.count_o, 32);
            end
            if (i == 32) begin
                chk("s3_overflow_set", overflow, 1);
            end
        end
        in_valid = 1'b0;
        chk("s3_count_after_stream", dut.u_fifo.count_o, 32);
        chk("s3_wr_en_waiting", wr_en, 1);
        // One extra beat pushed in the first ack cycle, while full and popping.
        run_cycles(50, 0, 8'hC0, 1'b1);
        chk("s3_num_bursts", nb, 8);
        chk("s3_num_beats", ng, 32);
        for (int i = 0; i < 32; i += 5) begin
            chk($sformatf("s3_beat%0d", i), got[i], beat(8'hC0, i));
        end
        chk("s3_beat31", got[31], beat(8'hC0, 31));
        chk("s3_full_push_kept", dut.u_fifo.count_o, 1);
        chk("s3_residual_head", dut.u_fifo.head_o, beat(8'hEE, 0));
        chk("s3_burst_count", burst_count, 8);
        chk("s3_overflow_sticky", overflow, 1);

        // Stray ack in IDLE with only two beats buffered.
        do_arm(29'h100, 29'h118, 1'b0);
        chk("s4_flushed", dut.u_fifo.count_o, 0);
        chk("s4_overflow_cleared", overflow, 0);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = beat(8'hD4, k);
            step();
        end
        in_valid = 1'b0;
        wr_ack   = 1'b1;
        step();
        wr_ack = 1'b0;
        chk("s4_no_valid", wr_valid, 0);
        chk("s4_no_pop", dut.u_fifo.count_o, 2);
        step();
        chk("s4_no_valid_later", wr_valid, 0);
        chk("s4_no_wr_en", wr_en, 0);

        // Stop after six beats: one burst, two beats left behind.
        do_arm(29'h100, 29'h118, 1'b0);
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = beat(8'hD0, k);
            step();
        end
        in_valid = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s5_capturing_off", capturing, 0);
        run_cycles(20, 0, 8'hD0, 1'b0);
        chk("s5_one_burst", nb, 1);
        chk("s5_num_beats", ng, 4);
        chk("s5_beat0", got[0], beat(8'hD0, 0));
        chk("s5_beat3", got[3], beat(8'hD0, 3));
        chk("s5_residual", dut.u_fifo.count_o, 2);
        in_valid = 1'b1;
        in_data  = beat(8'hDF, 0);
        step();
        in_valid = 1'b0;
        chk("s5_drop_no_overflow", overflow, 0);
        chk("s5_drop_no_push", dut.u_fifo.count_o, 2);
        do_arm(29'h200, 29'h218, 1'b1);
        chk("s5_armstop_capturing", capturing, 0);
        chk("s5_armstop_addr", wr_addr, 29'h200);
        chk("s5_armstop_flushed", dut.u_fifo.count_o, 0);
        chk("s5_armstop_count", burst_count, 0);

        // Reset asserted during the second beat of a burst.
        do_arm(29'h100, 29'h118, 1'b0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = beat(8'hE0, k);
            step();
        end
        in_valid = 1'b0;
        got_en = 1'b0;
        for (int k = 0; k < 10 && !got_en; k++) begin
            if (wr_en) got_en = 1'b1;
            else step();
        end
        chk("s6_wr_en_seen", got_en, 1);
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        chk("s6_b1_valid", wr_valid, 1);
        chk("s6_b1_data", wr_data, beat(8'hE0, 1));
        step();
        chk("s6_b2_data", wr_data, beat(8'hE0, 2));
        rst_n = 1'b0;
        #2;
        chk("s6_async_wr_en", wr_en, 0);
        chk("s6_async_wr_valid", wr_valid, 0);
        chk("s6_async_wr_addr", wr_addr, 0);
        chk("s6_async_wr_data", wr_data, 0);
        chk("s6_async_capturing", capturing, 0);
        chk("s6_async_overflow", overflow, 0);
        chk("s6_async_wrapped", wrapped, 0);
        chk("s6_async_burst_count", burst_count, 0);
        repeat (3) step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (wr_valid || wr_en) seen = 1'b1;
        end
        chk("s6_no_activity_after", seen, 0);
        chk("s6_fifo_empty", dut.u_fifo.count_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_burst_writer.md
LA_BURST_WRITER -- requirements
Module: la_burst_writer

Interface
REQ-001 Parameter DEPTH, 32, local beat buffer depth in 128-bit beats; power of two, at least 8.
REQ-002 Parameter BURST_BEATS, 4, beats per DRAM write burst; fixed at 4 (one 512-bit BL8 burst).
REQ-003 Parameter ADDR_STEP, 8, wr_addr increment per burst (DRAM column units).
REQ-004 clk_ram_2x  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 arm  in  1  one-cycle pulse: load addresses, clear status, start capture.
REQ-007 stop  in  1  one-cycle pulse: stop accepting input; pending full bursts still drain.
REQ-008 base_addr  in  29  first burst address, ADDR_STEP-aligned.
REQ-009 end_addr  in  29  last burst address (inclusive), ADDR_STEP-aligned.
REQ-010 in_valid  in  1  capture beat strobe.
REQ-011 in_data  in  128  capture beat.
REQ-012 wr_en  out  1  burst request to arbiter.
REQ-013 wr_valid  out  1  continuation beat valid.
REQ-014 wr_addr  out  29  burst address, stable while wr_en is high.
REQ-015 wr_data  out  128  current beat.
REQ-016 wr_ack  in  1  one-cycle grant; beat 0 is consumed in the ack cycle.
REQ-017 capturing  out  1  high from arm until stop.
REQ-018 overflow  out  1  sticky: in_valid beat dropped because the buffer was full.
REQ-019 wrapped  out  1  sticky: address has wrapped end_addr -> base_addr at least once.
REQ-020 burst_count  out  32  bursts completed since arm, saturating at 0xFFFFFFFF.

Function
REQ-021 Input beats are written to the buffer only when capturing=1, in_valid=1 and the buffer is not full; otherwise the beat is dropped, and overflow is set if capturing=1.
REQ-022 FSM states: IDLE, REQ, BURST.
REQ-023 IDLE -> REQ when the buffer holds at least BURST_BEATS beats; wr_en is registered and rises the cycle after the transition decision.
REQ-024 In REQ: wr_en=1, wr_valid=0, wr_data=buffer head (first-word fall-through); wr_data is combinational from the head so that it is valid in the ack cycle.
REQ-025 REQ + wr_ack=1: pop beat 0 the same cycle, go to BURST, drop wr_en on the next edge.
REQ-026 In BURST: wr_valid=1 and wr_data=head for exactly BURST_BEATS-1 consecutive cycles, popping one beat per cycle; no gaps are permitted.
REQ-027 After the last beat: burst_count+1, wr_addr+ADDR_STEP, or wr_addr=base_addr with wrapped set if wr_addr==end_addr; return to IDLE. The FSM holds at least one IDLE cycle between bursts.
REQ-028 wr_ack in IDLE or BURST is ignored.
REQ-029 A simultaneous push and pop leaves the occupancy unchanged; a push into a full buffer during a pop cycle is accepted.
REQ-030 arm while not IDLE: the current burst completes and the new base_addr takes effect at the next burst; the buffer is flushed only if arm arrives in IDLE.
REQ-031 arm in IDLE: flush the buffer, wr_addr=base_addr, clear overflow/wrapped/burst_count, set capturing.
REQ-032 stop: clear capturing next cycle; a residual buffer content below BURST_BEATS is discarded at the next arm.
REQ-033 Simultaneous arm and stop: stop wins, but addresses and status are still reloaded.

Reset
REQ-034 rst_n low forces IDLE, an empty buffer, and all outputs to 0, including wr_addr, wr_data, capturing and status.
REQ-035 rst_n low mid-burst abandons the burst immediately; no further wr_valid is issued after reset releases.
REQ-036 Reset deassertion is synchronised internally (two-flop) before the FSM leaves IDLE.

Structure
REQ-037 BURST_BEATS, ADDR_STEP, the 29-bit address width and the FSM state enum belong in a shared package (mem_pkg), which the arbiter also imports.
REQ-038 The beat buffer is a sub-module, la_beat_fifo: single-clock FWFT FIFO with occupancy output.
REQ-039 The FIFO data storage is block RAM or LUT RAM, implementation's choice; the head register provides FWFT.

Verification
REQ-040 Scenario: arm (base=0x100, end=0x118), 4 in_valid beats A0..A3, ack 3 cycles after wr_en -> wr_data=A0 in the ack cycle, then A1..A3 with wr_valid=1 on 3 consecutive cycles, wr_addr=0x100, and burst_count=1.
REQ-041 Scenario: 20 beats with immediate acks -> bursts at 0x100, 0x108, 0x110, 0x118, then 0x100 with wrapped=1.
REQ-042 Scenario: ack withheld while 40 beats are streamed, DEPTH=32 -> 8 beats dropped, overflow=1, and the first 32 beats drain in order.
REQ-043 Scenario: wr_ack pulsed in IDLE with 2 beats buffered -> no pop, wr_valid stays 0.
REQ-044 Scenario: rst_n low during the 2nd beat of BURST -> all outputs 0 asynchronously; after release there is no wr_valid, and FIFO occupancy is 0.
REQ-045 Scenario: stop after 6 beats -> exactly one burst issued, capturing=0, 2 beats retained, flushed by the next arm in IDLE.
